// File: rtl/comp_pkg.sv
// Shared types and encodings for the bit-serial magnitude comparator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_GT = 2'd0,
        RES_EQ = 2'd1,
        RES_LT = 2'd2
    } res_t;

    // Board LEDs are wired active-low.
    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

    // Map a result onto the {gt, eq, lt} LED triple.
    function automatic logic [2:0] res_to_leds(input res_t r);
        logic [2:0] leds;
        leds = {LED_OFF, LED_OFF, LED_OFF};
        case (r)
            RES_GT:  leds = {LED_ON,  LED_OFF, LED_OFF};
            RES_EQ:  leds = {LED_OFF, LED_ON,  LED_OFF};
            RES_LT:  leds = {LED_OFF, LED_OFF, LED_ON};
            default: leds = {LED_OFF, LED_OFF, LED_OFF};
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/comp_bit_cell.sv
// One-bit magnitude compare cell, chained MSB-first through gin/lin.
// Latency: combinational.
// Backpressure: none.
module comp_bit_cell
(
    input  logic xb,
    input  logic yb,
    input  logic gin,
    input  logic lin,
    output logic gout,
    output logic lout,
    output logic eout
);

    // A decision made at a more significant bit always wins over this bit.
    assign gout = gin | (~lin & xb & ~yb);
    assign lout = lin | (~gin & ~xb & yb);
    assign eout = ~gout & ~lout;

endmodule

// File: rtl/comp_seq.sv
// Bit-serial MSB-first magnitude comparator driving held active-low gt/eq/lt LEDs.
// Latency: WIDTH+1 cycles from accepted start to done (early exit with COMP_SEQ_EARLY_EXIT_EN: WIDTH-k+1, k = first differing bit).
// Backpressure: start is ignored (not queued) while busy, including the DONE cycle.
module comp_seq
    import comp_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             gt_led,
    output logic             eq_led,
    output logic             lt_led
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_xr;
    logic [WIDTH-1:0] r_yr;
    logic [IDX_W-1:0] r_idx;
    logic             r_gt;
    logic             r_lt;
    logic             r_busy;
    logic             r_done;
    logic             r_gt_led;
    logic             r_eq_led;
    logic             r_lt_led;

    logic             w_xb;
    logic             w_yb;
    logic             w_gout;
    logic             w_lout;
    logic             w_eout;
    logic             w_stop;
    res_t             w_res;
    logic [WIDTH-1:0] w_msb_flip;

    assign w_xb = r_xr[r_idx];
    assign w_yb = r_yr[r_idx];

    comp_bit_cell u_cell (
        .xb   (w_xb),
        .yb   (w_yb),
        .gin  (r_gt),
        .lin  (r_lt),
        .gout (w_gout),
        .lout (w_lout),
        .eout (w_eout)
    );

    // Flipping both MSBs turns two's-complement order into plain unsigned order.
    assign w_msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    // Decide when the scan ends and what the final result is.
    always_comb begin
`ifdef COMP_SEQ_EARLY_EXIT_EN
        w_stop = (r_idx == '0) || w_gout || w_lout;
`else
        w_stop = (r_idx == '0);
`endif
        if (w_eout)
            w_res = RES_EQ;
        else if (w_gout)
            w_res = RES_GT;
        else
            w_res = RES_LT;
    end

    // Control FSM with registered busy/done and held LED result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_xr     <= '0;
            r_yr     <= '0;
            r_idx    <= '0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_gt_led <= LED_OFF;
            r_eq_led <= LED_OFF;
            r_lt_led <= LED_OFF;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_xr    <= x ^ w_msb_flip;
                        r_yr    <= y ^ w_msb_flip;
                        r_idx   <= IDX_W'(WIDTH - 1);
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_gt <= w_gout;
                    r_lt <= w_lout;
                    if (w_stop) begin
                        r_done                         <= 1'b1;
                        {r_gt_led, r_eq_led, r_lt_led} <= res_to_leds(w_res);
                        r_state                        <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign gt_led = r_gt_led;
    assign eq_led = r_eq_led;
    assign lt_led = r_lt_led;

endmodule

// File: tb/tb_comp_seq.sv
// Testbench for comp_seq: WIDTH=8 vector table with a done/LED scoreboard, plus WIDTH=4/2 corners.
// Latency expectations follow COMP_SEQ_EARLY_EXIT_EN when defined.
// Backpressure: exercises ignored starts while busy and reset mid-run.
module tb_comp_seq;

    localparam logic [2:0] L_GT  = 3'b011;
    localparam logic [2:0] L_EQ  = 3'b101;
    localparam logic [2:0] L_LT  = 3'b110;
    localparam logic [2:0] L_OFF = 3'b111;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       sm;
        logic [2:0] leds;
        int         lat_e;
        int         lat_f;
    } vec_t;

    typedef struct {
        logic [2:0] leds;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance
    logic       start8 = 1'b0, sm8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic       busy8, done8, gt8, eq8, lt8;

    comp_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .x(x8), .y(y8), .busy(busy8), .done(done8),
        .gt_led(gt8), .eq_led(eq8), .lt_led(lt8)
    );

    // WIDTH=4 and WIDTH=2 instances share stimulus
    logic       start_s = 1'b0, sm_s = 1'b0;
    logic [3:0] x_s = '0, y_s = '0;
    logic       busy4, done4, gt4, eq4, lt4;
    logic       busy2, done2, gt2, eq2, lt2;

    comp_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .signed_mode(sm_s),
        .x(x_s), .y(y_s), .busy(busy4), .done(done4),
        .gt_led(gt4), .eq_led(eq4), .lt_led(lt4)
    );

    comp_seq #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .signed_mode(sm_s),
        .x(x_s[1:0]), .y(y_s[1:0]), .busy(busy2), .done(done2),
        .gt_led(gt2), .eq_led(eq2), .lt_led(lt2)
    );

    int n_chk = 0;
    int n_pass = 0;
    exp_t sb[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int pick_lat(input int lat_e, input int lat_f);
`ifdef COMP_SEQ_EARLY_EXIT_EN
        return lat_e;
`else
        return lat_f;
`endif
    endfunction

    // Scoreboard: every done8 pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done8) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("leds8", int'({gt8, eq8, lt8}), int'(e.leds));
                chk("busy_at_done", int'(busy8), 1);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 14 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        x8 = v.x; y8 = v.y; sm8 = v.sm; start8 = 1'b1;
        sb.push_back('{v.leds, cyc + pick_lat(v.lat_e, v.lat_f)});
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy_after_start", int'(busy8), 1);
        // operands are latched: scrambling them must not matter
        x8 = ~v.x; y8 = ~v.y; sm8 = ~v.sm;
        wait_drain();
        @(posedge clk); #1;
        chk("busy_idle", int'(busy8), 0);
    endtask

    vec_t vt[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int c0;
        int d4, d2, hold_bad;
        logic seen;

        vt[0] = '{8'hA5, 8'hA5, 1'b0, L_EQ, 9, 9};
        vt[1] = '{8'h80, 8'h7F, 1'b0, L_GT, 2, 9};
        vt[2] = '{8'h80, 8'h7F, 1'b1, L_LT, 2, 9};
        vt[3] = '{8'h01, 8'h02, 1'b0, L_LT, 8, 9};
        vt[4] = '{8'h10, 8'h0F, 1'b0, L_GT, 5, 9};
        vt[5] = '{8'hFF, 8'hFF, 1'b1, L_EQ, 9, 9};
        vt[6] = '{8'h7F, 8'hFF, 1'b1, L_GT, 2, 9};
        vt[7] = '{8'h00, 8'h01, 1'b0, L_LT, 9, 9};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_leds8", int'({gt8, eq8, lt8}), int'(L_OFF));
        chk("rst_leds4", int'({gt4, eq4, lt4}), int'(L_OFF));
        chk("rst_busy4", int'(busy4), 0);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // Second start during RUN and during DONE is ignored
        @(posedge clk); #1;
        x8 = 8'h01; y8 = 8'h02; sm8 = 1'b0; start8 = 1'b1;
        sb.push_back('{L_LT, cyc + pick_lat(8, 9)});
        @(posedge clk); #1;
        start8 = 1'b0; x8 = 8'hFF; y8 = 8'h00; sm8 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start8 = 1'b1;
        chk("busy_c3", int'(busy8), 1);
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy_c4", int'(busy8), 1);
        seen = 1'b0;
        for (int i = 0; i < 14 && !seen; i++) begin
            @(posedge clk); #1;
            if (done8) seen = 1'b1;
        end
        chk("ign_done_seen", int'(seen), 1);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("ign_done_pulse_len", int'(done8), 0);
        chk("ign_busy_after_done", int'(busy8), 0);
        repeat (14) @(posedge clk);
        #1;
        chk("ign_busy_stays_low", int'(busy8), 0);
        chk("ign_sb_empty", sb.size(), 0);
        sb.delete();

        // Reset mid-run, then start in the first cycle after release
        @(posedge clk); #1;
        x8 = 8'h00; y8 = 8'hFF; sm8 = 1'b0; start8 = 1'b1;
        c0 = cyc;
`ifdef COMP_SEQ_EARLY_EXIT_EN
        sb.push_back('{L_LT, c0 + 2});
`endif
        @(posedge clk); #1;
        start8 = 1'b0;
        while (cyc < c0 + 4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_busy", int'(busy8), 0);
        chk("rst_mid_done", int'(done8), 0);
        chk("rst_mid_leds", int'({gt8, eq8, lt8}), int'(L_OFF));
        chk("rst_mid_sb", sb.size(), 0);
        sb.delete();
        rst_n = 1'b1;
        x8 = 8'h10; y8 = 8'h0F; start8 = 1'b1;
        sb.push_back('{L_GT, cyc + pick_lat(5, 9)});
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("post_rst_busy", int'(busy8), 1);
        wait_drain();

        // WIDTH=4 signed -1 vs -2, WIDTH=2 signed -1 vs -2
        @(posedge clk); #1;
        x_s = 4'b1111; y_s = 4'b1110; sm_s = 1'b1; start_s = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start_s = 1'b0;
        d4 = -1; d2 = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done4 && d4 < 0) d4 = cyc - c0;
            if (done2 && d2 < 0) d2 = cyc - c0;
        end
        chk("w4_latency", d4, 5);
        chk("w2_latency", d2, 3);
        chk("w4_leds", int'({gt4, eq4, lt4}), int'(L_GT));
        chk("w2_leds", int'({gt2, eq2, lt2}), int'(L_GT));
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({gt4, eq4, lt4} != L_GT || busy4 || done4) hold_bad++;
        end
        chk("w4_hold", hold_bad, 0);

        chk("sb_empty_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
